flash_playback_streamer: RTL and testbench
==========================================

Name: flash_playback_streamer

Overview:
- Downstream of the flash/USB audio manager. Streams a stored 8-bit PCM clip out of flash to the AC97 headphone path.
- Walks a flash address range through the flash_manager read interface and prefetches samples into a small FIFO.
- On each AC97 ready strobe, presents one sample, repeating each stored sample REPEAT times (6 kHz file to 48 kHz codec).
- Replaces the ad-hoc raddr++ / to_ac97_data playback logic in the top level.

Parameters:
- FIFO_DEPTH, 8: prefetch FIFO entries; power of two, minimum 2.
- REPEAT, 8: AC97 ready strobes per stored sample; minimum 1.
- READ_WAIT, 4: clocks busy must be low after an raddr change before frdata is captured.

Ports:
- clock  in  1: 27 MHz system clock.
- reset  in  1: asynchronous, active-low reset.
- start  in  1: one-clock pulse; begin playback from start_addr.
- stop  in  1: one-clock pulse; abort playback.
- start_addr  in  23: first flash word of the clip; sampled on start.
- num_samples  in  23: clip length in flash words; sampled on start; 0 means start is ignored.
- loop  in  1: 1 = wrap to start_addr at clip end; sampled live.
- ready  in  1: AC97 sample strobe, one clock wide.
- to_ac97_data  out  8: PCM sample to the codec.
- raddr  out  23: flash read address, to flash_manager.
- doread  out  1: read enable, to flash_manager.
- busy  in  1: flash_manager busy.
- frdata  in  16: flash read data; the sample is frdata[15:8].
- playing  out  1: high from accepted start until the clip finishes or stop.
- done  out  1: one-clock pulse when a non-looped clip finishes.
- underruns  out  16: saturating count of ready strobes that found the FIFO empty while playing.

Behaviour:
- Reset values:
  - to_ac97_data=0, raddr=0, doread=0, playing=0, done=0, underruns=0.
  - FIFO empty, fetch FSM in IDLE, repeat counter 0.
- Fetch FSM states: IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE: on start with num_samples≠0:
    - latch base=start_addr, len=num_samples;
    - raddr<=start_addr, fetched=0, underruns=0, playing<=1, doread<=1;
    - go to ISSUE.
  - ISSUE: if FIFO not full and fetched<len, go to WAIT and clear the wait counter; otherwise stay.
  - WAIT: the counter increments on each clock with busy=0 and clears on busy=1. When it reaches READ_WAIT, go to CAPTURE.
  - CAPTURE (one clock):
    - push frdata[15:8] into the FIFO;
    - fetched+1, raddr+1;
    - if fetched+1==len and loop=1: raddr<=base and fetched<=0;
    - return to ISSUE.
- Output side, on each ready while playing:
  - FIFO non-empty: to_ac97_data<=FIFO head and the repeat counter increments. When the counter reaches REPEAT-1 it resets to 0 and the head is popped. Each sample is therefore output exactly REPEAT times.
  - FIFO empty: to_ac97_data<=0x00, underruns+1 (saturating at 0xFFFF), repeat counter unchanged. Does not apply during the end-of-clip drain (see Completion).
  - ready while not playing: to_ac97_data<=0x00.
- Completion (loop=0):
  - Condition: fetched==len, FIFO empty, and the last sample has had its REPEAT outputs.
  - Next clock: playing<=0, doread<=0, done=1 for one clock, FSM to IDLE. to_ac97_data holds the last sample until the next ready, which outputs 0.
- A FIFO push and pop in the same clock are both honoured; occupancy is unchanged.
- Full FIFO: fetch stalls in ISSUE with raddr held. Empty FIFO: no pop.
- start while playing:
  - restart: flush the FIFO, repeat counter=0, relatch start_addr/num_samples, underruns=0, FSM to ISSUE;
  - an in-flight capture is discarded;
  - done is not pulsed.
- stop (any state):
  - flush the FIFO; playing<=0, doread<=0, FSM to IDLE, to_ac97_data<=0;
  - no done pulse.
  - stop and start in the same clock: stop wins.
- raddr arithmetic is 23-bit modulo; 0x7FFFFF+1 wraps to 0.
- Reset asserted mid-clip forces all reset values immediately (asynchronous); no done pulse.
- busy high for any length only delays CAPTURE; no timeout.

Test Plan:
- Preload words 100..103 with upper bytes 0x10,0x20,0x30,0x40. start_addr=100, num_samples=4, REPEAT=8, model busy low → 32 ready strobes yield 8×0x10, 8×0x20, 8×0x30, 8×0x40. done pulses once, playing=0, underruns=0, raddr last issued=103.
- Same clip with loop=1, 40 strobes → output resumes 0x10 after 0x40 (strobe 33); raddr returns to 100; playing stays 1; no done pulse.
- Model busy held high for 2000 clocks after start while ready strobes every 562 clocks → outputs 0x00. underruns=3 after the first 3 strobes (as counted while busy is still high; the count is not frozen). Playback then proceeds with correct samples.
- Assert stop mid-clip after 10 strobes → next clock: playing=0, doread=0, to_ac97_data=0, FIFO empty. A subsequent start with start_addr=102 plays 0x30 first.
- start pulse during playback with start_addr=103, num_samples=1 → old samples flushed; 8×0x40 then done.
- Drop reset low during a WAIT state → all outputs at reset values within the same clock. num_samples=0 start → ignored, playing stays 0.

Source files
------------

// File: rtl/flash_playback_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : flash_playback_streamer_if
//  Purpose  : Read bus between the playback streamer and the flash manager.
//             The master drives the word address and read enable, the slave
//             returns busy and the 16-bit read word.
//  Revision : 1.0  initial release
// ============================================================================
interface flash_playback_streamer_if;
   logic [22:0] raddr;
   logic        doread;
   logic        busy;
   logic [15:0] frdata;

   modport master (output raddr, output doread, input busy, input frdata);
   modport slave  (input raddr, input doread, output busy, output frdata);
endinterface
`default_nettype wire

// File: rtl/flash_playback_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : flash_playback_streamer
//  Purpose  : Streams an 8-bit PCM clip stored in flash to the AC97 path.
//             A fetch FSM walks the clip address range and prefetches sample
//             bytes into a small FIFO. Each AC97 ready strobe presents the
//             FIFO head, repeating every stored sample REPEAT times.
//  Revision : 1.0  initial release
// ============================================================================
module flash_playback_streamer #(
   parameter int FIFO_DEPTH = 8,
   parameter int REPEAT     = 8,
   parameter int READ_WAIT  = 4
) (
   input  wire                       clock,
   input  wire                       reset,
   input  wire                       start,
   input  wire                       stop,
   input  wire  [22:0]               start_addr,
   input  wire  [22:0]               num_samples,
   input  wire                       loop,
   input  wire                       ready,
   output logic [7:0]                to_ac97_data,
   flash_playback_streamer_if.master flash,
   output logic                      playing,
   output logic                      done,
   output logic [15:0]               underruns
);

   localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = c_PTR_W + 1;
   localparam int c_REP_W  = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam int c_WAIT_W = $clog2(READ_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t              r_state;
   logic [22:0]         r_base;
   logic [22:0]         r_len;
   logic [22:0]         r_fetched;
   logic [22:0]         r_raddr;
   logic                r_doread;
   logic                r_playing;
   logic                r_done;
   logic [c_WAIT_W-1:0] r_wait_cnt;

   logic [7:0]          r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic [c_REP_W-1:0]  r_rep_cnt;
   logic [7:0]          r_sample;
   logic [15:0]         r_underruns;

   logic w_start_ok;
   logic w_full;
   logic w_empty;
   logic w_drain;
   logic w_complete;
   logic w_push;
   logic w_pop;
   logic w_rep_last;
   logic w_ready_play;
   logic w_unused;

   // A start is only honoured for a non-empty clip, and stop overrides it.
   assign w_start_ok   = start && !stop && (num_samples != 23'd0);
   assign w_full       = (r_count == c_CNT_W'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   // Every word of a non-looped clip has been fetched; only draining remains.
   assign w_drain      = (r_fetched == r_len);
   assign w_complete   = r_playing && w_drain && w_empty && (r_rep_cnt == '0);
   // Restart and stop both discard whatever capture is in progress.
   assign w_push       = (r_state == S_CAPTURE) && !stop && !w_start_ok;
   assign w_ready_play = ready && r_playing && !stop && !w_start_ok;
   assign w_rep_last   = (r_rep_cnt == c_REP_W'(REPEAT - 1));
   assign w_pop        = w_ready_play && !w_empty && w_rep_last;
   assign w_unused     = ^flash.frdata[7:0];

   assign flash.raddr  = r_raddr;
   assign flash.doread = r_doread;
   assign playing      = r_playing;
   assign done         = r_done;
   assign to_ac97_data = r_sample;
   assign underruns    = r_underruns;

   // Fetch FSM: issues flash addresses and decides when each read word is valid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_fetched  <= '0;
         r_raddr    <= '0;
         r_doread   <= 1'b0;
         r_playing  <= 1'b0;
         r_done     <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            r_state   <= S_IDLE;
            r_playing <= 1'b0;
            r_doread  <= 1'b0;
         end else if (w_start_ok) begin
            r_base    <= start_addr;
            r_len     <= num_samples;
            r_raddr   <= start_addr;
            r_fetched <= '0;
            r_playing <= 1'b1;
            r_doread  <= 1'b1;
            r_state   <= S_ISSUE;
         end else if (w_complete) begin
            r_playing <= 1'b0;
            r_doread  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
         end else begin
            case (r_state)
               S_ISSUE: begin
                  if (!w_full && (r_fetched < r_len)) begin
                     r_state    <= S_WAIT;
                     r_wait_cnt <= '0;
                  end
               end
               S_WAIT: begin
                  // Need READ_WAIT consecutive non-busy clocks on a stable address.
                  if (flash.busy) begin
                     r_wait_cnt <= '0;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                     if (r_wait_cnt == c_WAIT_W'(READ_WAIT - 1)) begin
                        r_state <= S_CAPTURE;
                     end
                  end
               end
               S_CAPTURE: begin
                  if (((r_fetched + 23'd1) == r_len) && loop) begin
                     r_raddr   <= r_base;
                     r_fetched <= '0;
                  end else begin
                     r_raddr   <= r_raddr + 23'd1;
                     r_fetched <= r_fetched + 23'd1;
                  end
                  r_state <= S_ISSUE;
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   // Prefetch storage; contents need no reset because occupancy is tracked.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= flash.frdata[15:8];
      end
   end

   // Output side: FIFO pointers, sample repetition and underrun accounting.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rep_cnt   <= '0;
         r_sample    <= 8'h00;
         r_underruns <= '0;
      end else if (stop || w_start_ok) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rep_cnt <= '0;
         if (stop) begin
            r_sample <= 8'h00;
         end else begin
            r_underruns <= '0;
         end
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         if (ready) begin
            if (!r_playing) begin
               r_sample <= 8'h00;
            end else if (!w_empty) begin
               r_sample  <= r_mem[r_rd_ptr];
               r_rep_cnt <= w_rep_last ? '0 : r_rep_cnt + 1'b1;
            end else begin
               r_sample <= 8'h00;
               // An empty FIFO at the tail of a one-shot clip is not starvation.
               if (!w_drain && (r_underruns != 16'hFFFF)) begin
                  r_underruns <= r_underruns + 16'd1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flash_playback_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_playback_streamer
//  Purpose  : Self-checking bench for flash_playback_streamer with a simple
//             flash model and a queue of expected AC97 samples.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flash_playback_streamer;

   localparam int c_FIFO_DEPTH = 8;
   localparam int c_REPEAT     = 8;
   localparam int c_READ_WAIT  = 4;
   localparam int c_GAP        = 19;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic [22:0] start_addr;
   logic [22:0] num_samples;
   logic        loop;
   logic        ready;
   logic        busy_model;
   logic [7:0]  to_ac97_data;
   logic        playing;
   logic        done;
   logic [15:0] underruns;

   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   logic [7:0]  exp_q [$];

   flash_playback_streamer_if flash_bus ();

   flash_playback_streamer #(
      .FIFO_DEPTH (c_FIFO_DEPTH),
      .REPEAT     (c_REPEAT),
      .READ_WAIT  (c_READ_WAIT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .start_addr   (start_addr),
      .num_samples  (num_samples),
      .loop         (loop),
      .ready        (ready),
      .to_ac97_data (to_ac97_data),
      .flash        (flash_bus.master),
      .playing      (playing),
      .done         (done),
      .underruns    (underruns)
   );

   always #5 clock = ~clock;

   // Flash contents: the test clip at 100..103, an address-derived pattern elsewhere.
   function automatic logic [15:0] flash_word(input logic [22:0] a);
      case (a)
         23'd100: flash_word = 16'h10C3;
         23'd101: flash_word = 16'h20C3;
         23'd102: flash_word = 16'h30C3;
         23'd103: flash_word = 16'h40C3;
         default: flash_word = {a[7:0] ^ 8'h5A, 8'h3C};
      endcase
   endfunction

   assign flash_bus.frdata = flash_word(flash_bus.raddr);
   assign flash_bus.busy   = busy_model;

   // Count done pulses seen mid-cycle.
   always @(negedge clock) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(negedge clock);
      ready = 1'b0;
   endtask

   task automatic pulse_start(input logic [22:0] a, input logic [22:0] n);
      start_addr  = a;
      num_samples = n;
      start       = 1'b1;
      @(negedge clock);
      start       = 1'b0;
   endtask

   task automatic push_sample(input logic [7:0] b);
      repeat (c_REPEAT) exp_q.push_back(b);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; ready = 1'b0;
      busy_model = 1'b0; start_addr = '0; num_samples = '0;
      idle(3);
      n_vec++;
      if ({to_ac97_data, flash_bus.raddr, flash_bus.doread, playing, done, underruns} !== '0) begin
         n_err++;
         $display("FAIL reset_values: got data=%h raddr=%h doread=%b playing=%b done=%b und=%h expected all zero",
                  to_ac97_data, flash_bus.raddr, flash_bus.doread, playing, done, underruns);
      end
      reset = 1'b1;
      idle(2);
   endtask

   task automatic test_single_shot();
      int d0;
      logic [7:0] exp;
      d0 = done_cnt;
      loop = 1'b0;
      push_sample(8'h10); push_sample(8'h20); push_sample(8'h30); push_sample(8'h40);
      pulse_start(23'd100, 23'd4);
      idle(60);
      for (int i = 0; i < 4 * c_REPEAT; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL single_shot strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      n_vec++;
      if ((done_cnt - d0) != 1 || playing !== 1'b0 || underruns !== 16'd0) begin
         n_err++;
         $display("FAIL single_shot_end: got done_pulses=%0d playing=%b und=%0d expected 1,0,0",
                  done_cnt - d0, playing, underruns);
      end
      // Address has moved one past the last captured word (103).
      n_vec++;
      if (flash_bus.raddr !== 23'd104 || flash_bus.doread !== 1'b0) begin
         n_err++;
         $display("FAIL single_shot_raddr: got raddr=%0d doread=%b expected 104,0", flash_bus.raddr, flash_bus.doread);
      end
      n_vec++;
      if (to_ac97_data !== 8'h40) begin
         n_err++;
         $display("FAIL hold_last_sample: got %02h expected 40", to_ac97_data);
      end
      pulse_ready();
      n_vec++;
      if (to_ac97_data !== 8'h00 || underruns !== 16'd0) begin
         n_err++;
         $display("FAIL ready_when_idle: got data=%02h und=%0d expected 00,0", to_ac97_data, underruns);
      end
      idle(4);
   endtask

   task automatic test_loop();
      int d0;
      logic [7:0] exp;
      d0 = done_cnt;
      loop = 1'b1;
      push_sample(8'h10); push_sample(8'h20); push_sample(8'h30); push_sample(8'h40);
      push_sample(8'h10);
      pulse_start(23'd100, 23'd4);
      idle(60);
      // FIFO is full after two passes, leaving the address wrapped back to the base.
      n_vec++;
      if (flash_bus.raddr !== 23'd100) begin
         n_err++;
         $display("FAIL loop_raddr_wrap: got %0d expected 100", flash_bus.raddr);
      end
      for (int i = 0; i < 5 * c_REPEAT; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL loop strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      n_vec++;
      if (playing !== 1'b1 || done_cnt != d0 || underruns !== 16'd0) begin
         n_err++;
         $display("FAIL loop_state: got playing=%b done_pulses=%0d und=%0d expected 1,0,0",
                  playing, done_cnt - d0, underruns);
      end
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      loop = 1'b0;
      idle(4);
      n_vec++;
      if (playing !== 1'b0 || done_cnt != d0) begin
         n_err++;
         $display("FAIL loop_stop: got playing=%b done_pulses=%0d expected 0,0", playing, done_cnt - d0);
      end
   endtask

   task automatic test_busy_stall();
      int d0;
      logic [7:0] exp;
      d0 = done_cnt;
      busy_model = 1'b1;
      repeat (3) exp_q.push_back(8'h00);
      push_sample(8'h10); push_sample(8'h20); push_sample(8'h30); push_sample(8'h40);
      pulse_start(23'd100, 23'd4);
      for (int i = 0; i < 3; i++) begin
         idle(561);
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL busy_underrun strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
      end
      idle(2000 - 3 * 562);
      n_vec++;
      if (underruns !== 16'd3) begin
         n_err++;
         $display("FAIL busy_underrun_count: got %0d expected 3", underruns);
      end
      busy_model = 1'b0;
      idle(60);
      for (int i = 0; i < 4 * c_REPEAT; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL busy_resume strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      n_vec++;
      if ((done_cnt - d0) != 1 || underruns !== 16'd3) begin
         n_err++;
         $display("FAIL busy_end: got done_pulses=%0d und=%0d expected 1,3", done_cnt - d0, underruns);
      end
   endtask

   task automatic test_stop();
      int d0;
      logic [7:0] exp;
      d0 = done_cnt;
      push_sample(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h20);
      pulse_start(23'd100, 23'd4);
      idle(60);
      for (int i = 0; i < 10; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL stop_pre strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      n_vec++;
      if (playing !== 1'b0 || flash_bus.doread !== 1'b0 || to_ac97_data !== 8'h00) begin
         n_err++;
         $display("FAIL stop_state: got playing=%b doread=%b data=%02h expected 0,0,00",
                  playing, flash_bus.doread, to_ac97_data);
      end
      idle(5);
      n_vec++;
      if (done_cnt != d0) begin
         n_err++;
         $display("FAIL stop_no_done: got %0d pulses expected 0", done_cnt - d0);
      end
      push_sample(8'h30); push_sample(8'h40);
      pulse_start(23'd102, 23'd2);
      idle(60);
      for (int i = 0; i < 2 * c_REPEAT; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL stop_restart strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      n_vec++;
      if ((done_cnt - d0) != 1 || playing !== 1'b0) begin
         n_err++;
         $display("FAIL stop_restart_end: got done_pulses=%0d playing=%b expected 1,0", done_cnt - d0, playing);
      end
   endtask

   task automatic test_restart();
      int d0;
      logic [7:0] exp;
      d0 = done_cnt;
      repeat (5) exp_q.push_back(8'h10);
      pulse_start(23'd100, 23'd4);
      idle(60);
      for (int i = 0; i < 5; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL restart_pre strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      push_sample(8'h40);
      pulse_start(23'd103, 23'd1);
      idle(40);
      for (int i = 0; i < c_REPEAT; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL restart strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      n_vec++;
      if ((done_cnt - d0) != 1 || playing !== 1'b0) begin
         n_err++;
         $display("FAIL restart_end: got done_pulses=%0d playing=%b expected 1,0", done_cnt - d0, playing);
      end
   endtask

   task automatic test_addr_wrap();
      logic [7:0] exp;
      push_sample(8'hA4); push_sample(8'hA5); push_sample(8'h5A);
      pulse_start(23'h7FFFFE, 23'd3);
      idle(60);
      for (int i = 0; i < 3 * c_REPEAT; i++) begin
         pulse_ready();
         exp = exp_q.pop_front();
         n_vec++;
         if (to_ac97_data !== exp) begin
            n_err++;
            $display("FAIL addr_wrap strobe %0d: got %02h expected %02h", i, to_ac97_data, exp);
         end
         idle(c_GAP);
      end
      n_vec++;
      if (flash_bus.raddr !== 23'd1 || playing !== 1'b0) begin
         n_err++;
         $display("FAIL addr_wrap_end: got raddr=%h playing=%b expected 000001,0", flash_bus.raddr, playing);
      end
   endtask

   task automatic test_async_reset_and_zero_len();
      int d0;
      busy_model = 1'b1;
      pulse_start(23'd100, 23'd4);
      idle(10);
      pulse_ready();
      idle(5);
      pulse_ready();
      idle(5);
      n_vec++;
      if (underruns !== 16'd2 || playing !== 1'b1 || flash_bus.raddr !== 23'd100) begin
         n_err++;
         $display("FAIL pre_reset: got und=%0d playing=%b raddr=%0d expected 2,1,100",
                  underruns, playing, flash_bus.raddr);
      end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({to_ac97_data, flash_bus.raddr, flash_bus.doread, playing, done, underruns} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got data=%h raddr=%h doread=%b playing=%b done=%b und=%h expected all zero",
                  to_ac97_data, flash_bus.raddr, flash_bus.doread, playing, done, underruns);
      end
      @(negedge clock);
      reset = 1'b1;
      busy_model = 1'b0;
      idle(2);
      d0 = done_cnt;
      pulse_start(23'd200, 23'd0);
      idle(10);
      n_vec++;
      if (playing !== 1'b0 || flash_bus.doread !== 1'b0 || done_cnt != d0) begin
         n_err++;
         $display("FAIL zero_len_start: got playing=%b doread=%b done_pulses=%0d expected 0,0,0",
                  playing, flash_bus.doread, done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_loop();
      test_busy_stall();
      test_stop();
      test_restart();
      test_addr_wrap();
      test_async_reset_and_zero_len();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
